// File: rtl/spi_ram_master_seq.sv
// spi_ram_master_seq
//   Host-side sequencer for the SPI slave + single-port RAM wrapper. One
//   read or write command is accepted at a time over a valid/ready port.
//   Each command is serialized as an address frame followed by a data frame
//   on SS_n/MOSI. Read data frames then wait RD_LAT cycles and capture
//   ADDR_W bits from MISO (MSB first). The captured byte is returned with a
//   one-cycle rsp_valid strobe.
//
//   Frame shape: LEAD (1 cycle, SS_n low, MOSI 0), then SHIFT (ADDR_W+3
//   cycles: code[1], code[1], code[0], payload MSB first). Read-data frames
//   add RD_WAIT (RD_LAT cycles) and RD_CAP (ADDR_W cycles). Every frame is
//   followed by GAP_CYC cycles with SS_n high.
//   Frame codes: 00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data.
//
// Optional feature (macro ADDR_CACHE_EN):
//   The sequencer remembers the last write address and the last read
//   address, each with a valid flag. A command whose address matches the
//   cached address of the same direction skips the address frame.
//
// Ports:
//   wclk       in   clock, posedge
//   wrst       in   synchronous active-high reset
//   cmd_valid  in   host command present
//   cmd_ready  out  command can be accepted (registered, IDLE only)
//   cmd_rw     in   1 = read, 0 = write
//   cmd_addr   in   RAM address
//   cmd_wdata  in   write data
//   rsp_valid  out  one-cycle read-data strobe
//   rsp_rdata  out  last read data, held until the next read completes
//   busy       out  transaction in progress
//   SS_n       out  slave select, active low
//   MOSI       out  serial data to slave
//   MISO       in   serial data from slave

module spi_ram_master_seq #(
  parameter int ADDR_W  = 8,
  parameter int RD_LAT  = 2,
  parameter int GAP_CYC = 1
) (
  input  logic              wclk,
  input  logic              wrst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rw,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [ADDR_W-1:0] rsp_rdata,
  output logic              busy,
  output logic              SS_n,
  output logic              MOSI,
  input  logic              MISO
);

  localparam int SHIFT_LEN = ADDR_W + 3;
  localparam int CNT_W     = $clog2(SHIFT_LEN + RD_LAT + GAP_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LEAD, S_SHIFT, S_RD_WAIT, S_RD_CAP, S_GAP, S_DONE
  } state_t;

  state_t               r_state;
  logic                 r_rw;
  logic [ADDR_W-1:0]    r_addr;
  logic [ADDR_W-1:0]    r_wdata;
  logic                 r_dataFrame;
  logic [CNT_W-1:0]     r_bitCnt;
  logic [SHIFT_LEN-1:0] r_txShift;
  logic [ADDR_W-1:0]    r_rxShift;
  logic                 r_cmdReady;
  logic                 r_rspValid;
  logic [ADDR_W-1:0]    r_rspRdata;
  logic                 r_busy;
  logic                 r_ssN;
  logic                 r_mosi;

  logic                 w_accept;
  logic                 w_skip;
  logic                 w_shiftLast;
  logic [SHIFT_LEN-1:0] w_acceptFrame;
  logic [SHIFT_LEN-1:0] w_dataFrame;

  // The code's MSB is sent twice, ahead of the code LSB and the payload.
  function automatic logic [SHIFT_LEN-1:0] buildFrame(input logic [1:0] code,
                                                      input logic [ADDR_W-1:0] payload);
    return {code[1], code, payload};
  endfunction

  assign w_accept    = cmd_valid && r_cmdReady;
  assign w_shiftLast = (r_state == S_SHIFT) && (r_bitCnt == CNT_W'(SHIFT_LEN - 1));

  // The data frame carries wdata on a write; a read clocks out an all-zero payload.
  assign w_dataFrame   = buildFrame({r_rw, 1'b1}, r_rw ? '0 : r_wdata);
  assign w_acceptFrame = w_skip ? buildFrame({cmd_rw, 1'b1}, cmd_rw ? '0 : cmd_wdata)
                                : buildFrame({cmd_rw, 1'b0}, cmd_addr);

`ifdef ADDR_CACHE_EN
  logic [ADDR_W-1:0] r_lastWrAddr;
  logic [ADDR_W-1:0] r_lastRdAddr;
  logic              r_lastWrValid;
  logic              r_lastRdValid;

  // The address frame can be skipped only when the slave already holds this
  // address for the same direction.
  assign w_skip = cmd_rw ? (r_lastRdValid && (cmd_addr == r_lastRdAddr))
                         : (r_lastWrValid && (cmd_addr == r_lastWrAddr));

  // The cache is refreshed when an address frame finishes shifting.
  // A frame aborted by reset never updates it.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      r_lastWrAddr  <= '0;
      r_lastRdAddr  <= '0;
      r_lastWrValid <= 1'b0;
      r_lastRdValid <= 1'b0;
    end else if (w_shiftLast && !r_dataFrame) begin
      if (r_rw) begin
        r_lastRdAddr  <= r_addr;
        r_lastRdValid <= 1'b1;
      end else begin
        r_lastWrAddr  <= r_addr;
        r_lastWrValid <= 1'b1;
      end
    end
  end
`else
  assign w_skip = 1'b0;
`endif

  // Frame sequencer. Every pin-level output is a register, so a state's
  // outputs are set on the edge that enters that state. r_bitCnt restarts
  // at zero on every state change, so each frame starts from a clean count.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      r_state     <= S_IDLE;
      r_rw        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_dataFrame <= 1'b0;
      r_bitCnt    <= '0;
      r_txShift   <= '0;
      r_rxShift   <= '0;
      r_cmdReady  <= 1'b0;
      r_rspValid  <= 1'b0;
      r_rspRdata  <= '0;
      r_busy      <= 1'b0;
      r_ssN       <= 1'b1;
      r_mosi      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cmdReady <= 1'b1;
          if (w_accept) begin
            r_rw        <= cmd_rw;
            r_addr      <= cmd_addr;
            r_wdata     <= cmd_wdata;
            r_dataFrame <= w_skip;
            r_txShift   <= w_acceptFrame;
            r_cmdReady  <= 1'b0;
            r_busy      <= 1'b1;
            r_ssN       <= 1'b0;
            r_mosi      <= 1'b0;
            r_bitCnt    <= '0;
            r_state     <= S_LEAD;
          end
        end
        S_LEAD: begin
          r_mosi    <= r_txShift[SHIFT_LEN-1];
          r_txShift <= r_txShift << 1;
          r_bitCnt  <= '0;
          r_state   <= S_SHIFT;
        end
        S_SHIFT: begin
          if (w_shiftLast) begin
            r_mosi   <= 1'b0;
            r_bitCnt <= '0;
            if (r_rw && r_dataFrame) begin
              r_state <= S_RD_WAIT;
            end else begin
              r_ssN   <= 1'b1;
              r_state <= S_GAP;
            end
          end else begin
            r_mosi    <= r_txShift[SHIFT_LEN-1];
            r_txShift <= r_txShift << 1;
            r_bitCnt  <= r_bitCnt + 1'b1;
          end
        end
        S_RD_WAIT: begin
          if (r_bitCnt == CNT_W'(RD_LAT - 1)) begin
            r_bitCnt <= '0;
            r_state  <= S_RD_CAP;
          end else begin
            r_bitCnt <= r_bitCnt + 1'b1;
          end
        end
        S_RD_CAP: begin
          r_rxShift <= {r_rxShift[ADDR_W-2:0], MISO};
          if (r_bitCnt == CNT_W'(ADDR_W - 1)) begin
            r_bitCnt <= '0;
            r_ssN    <= 1'b1;
            r_state  <= S_GAP;
          end else begin
            r_bitCnt <= r_bitCnt + 1'b1;
          end
        end
        S_GAP: begin
          if (r_bitCnt == CNT_W'(GAP_CYC - 1)) begin
            r_bitCnt <= '0;
            if (!r_dataFrame) begin
              r_dataFrame <= 1'b1;
              r_txShift   <= w_dataFrame;
              r_ssN       <= 1'b0;
              r_state     <= S_LEAD;
            end else begin
              r_rspValid <= r_rw;
              if (r_rw) begin
                r_rspRdata <= r_rxShift;
              end
              r_state <= S_DONE;
            end
          end else begin
            r_bitCnt <= r_bitCnt + 1'b1;
          end
        end
        S_DONE: begin
          r_rspValid <= 1'b0;
          r_busy     <= 1'b0;
          r_cmdReady <= 1'b1;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready = r_cmdReady;
  assign rsp_valid = r_rspValid;
  assign rsp_rdata = r_rspRdata;
  assign busy      = r_busy;
  assign SS_n      = r_ssN;
  assign MOSI      = r_mosi;

endmodule
